// File: rtl/alu_writeback_buffer.sv
// ALU writeback buffer: 2-entry in-order result FIFO committing to the register file and flags,
// with youngest-first bypass of pending results onto the operand and flags read ports.
module alu_writeback_buffer #(
  parameter int DataWidth    = 16,
  parameter int RegAddrWidth = 3,
  parameter int FlagWidth    = 5
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [RegAddrWidth-1:0] InAddr,
  input  logic                    InWriteReg,
  input  logic                    InWriteFlags,
  input  logic [DataWidth-1:0]    InResult,
  input  logic [FlagWidth-1:0]    InFlags,
  input  logic [RegAddrWidth-1:0] SrcAddr,
  input  logic [RegAddrWidth-1:0] DestAddr,
  output logic [DataWidth-1:0]    SrcData,
  output logic [DataWidth-1:0]    DestData,
  output logic [FlagWidth-1:0]    FlagsOut,
  input  logic                    DebugWrite,
  input  logic [RegAddrWidth-1:0] DebugAddr,
  input  logic [DataWidth-1:0]    DebugData,
  output logic                    CommitValid,
  output logic [RegAddrWidth-1:0] CommitAddr
);

  localparam int NumRegs = 2 ** RegAddrWidth;

  typedef struct packed {
    logic [RegAddrWidth-1:0] addr;
    logic                    wreg;
    logic                    wflags;
    logic [DataWidth-1:0]    result;
    logic [FlagWidth-1:0]    flags;
  } entry_t;

  // Head is always the oldest entry; tail is only meaningful when two entries are held.
  entry_t                  head_q, head_d;
  entry_t                  tail_q, tail_d;
  logic [1:0]              count_q, count_d;
  logic [DataWidth-1:0]    regs_q [NumRegs];
  logic [FlagWidth-1:0]    flags_q;
  logic                    commit_valid_q;
  logic [RegAddrWidth-1:0] commit_addr_q;

  logic   accept_s;
  logic   commit_s;
  entry_t new_entry_s;

  function automatic logic [DataWidth-1:0] bypass_read(
    input logic [RegAddrWidth-1:0] addr,
    input entry_t                  head,
    input entry_t                  tail,
    input logic [1:0]              count,
    input logic [DataWidth-1:0]    rf_val
  );
    logic [DataWidth-1:0] val;
    if ((count == 2'd2) && tail.wreg && (tail.addr == addr)) begin
      val = tail.result;
    end else if ((count != 2'd0) && head.wreg && (head.addr == addr)) begin
      val = head.result;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  assign InReady     = (count_q != 2'd2);
  assign accept_s    = InValid && (count_q != 2'd2);
  assign commit_s    = (count_q != 2'd0) && !DebugWrite;
  assign new_entry_s = '{addr: InAddr, wreg: InWriteReg, wflags: InWriteFlags,
                         result: InResult, flags: InFlags};

  // FIFO next state: shift tail into head on commit, place the new entry behind the survivor.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({commit_s, accept_s})
      2'b01: begin
        if (count_q == 2'd0) begin
          head_d = new_entry_s;
        end else begin
          tail_d = new_entry_s;
        end
        count_d = count_q + 2'd1;
      end
      2'b10: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = new_entry_s;
        end else begin
          head_d = tail_q;
          tail_d = new_entry_s;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Buffer state and registered commit report.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= 2'd0;
      commit_valid_q <= 1'b0;
      commit_addr_q  <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_s;
      if (commit_s) begin
        commit_addr_q <= head_q.addr;
      end else begin
        commit_addr_q <= commit_addr_q;
      end
    end
  end

  // Architectural state; a debug write stalls commit, so the two never collide.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      flags_q <= '0;
    end else begin
      if (DebugWrite) begin
        regs_q[DebugAddr] <= DebugData;
      end else if (commit_s && head_q.wreg) begin
        regs_q[head_q.addr] <= head_q.result;
      end else begin
        regs_q[head_q.addr] <= regs_q[head_q.addr];
      end
      if (commit_s && head_q.wflags) begin
        flags_q <= head_q.flags;
      end else begin
        flags_q <= flags_q;
      end
    end
  end

  // Operand and flags bypass, youngest pending entry first.
  always_comb begin
    SrcData  = bypass_read(SrcAddr, head_q, tail_q, count_q, regs_q[SrcAddr]);
    DestData = bypass_read(DestAddr, head_q, tail_q, count_q, regs_q[DestAddr]);
    if ((count_q == 2'd2) && tail_q.wflags) begin
      FlagsOut = tail_q.flags;
    end else if ((count_q != 2'd0) && head_q.wflags) begin
      FlagsOut = head_q.flags;
    end else begin
      FlagsOut = flags_q;
    end
  end

  assign CommitValid = commit_valid_q;
  assign CommitAddr  = commit_addr_q;

endmodule
